dm12_32_bit_buf: RTL and testbench

- Buffered 1-to-2 demultiplexer for 32-bit datapath words; the steering counterpart to the 2:1 operand mux.
- Routes each accepted input word to one of two output channels selected by `in_sel`.
- Each channel has its own small FIFO with valid/ready handshakes.
- Sits between the ALU/multdiv result path and two consumers (e.g. register-file writeback and store/forward path), decoupling consumer stalls from the producer.

---
 rtl/dm12_32_bit_buf.sv | 122 ++++++++++++
 tb/tb_dm12_32_bit_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm12_32_bit_buf.sv
// dm12_32_bit_buf -- buffered 1-to-2 demultiplexer for datapath words.
//
// Each accepted input word is steered by in_sel into one of two independent
// output FIFOs (DEPTH entries each).
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_data/in_sel        : word and destination channel (0 or 1)
//   in_valid/in_ready     : producer handshake; in_ready reflects only the
//                           selected channel's fullness
//   outK_data/outK_valid  : channel K head word and non-empty flag
//   outK_ready            : channel K consumer takes the head this cycle
//   in_bcast              : only when DM12_BROADCAST_EN is defined; pushes the
//                           word into both channels
//
// Optional feature macro: DM12_BROADCAST_EN (broadcast push to both channels).
module dm12_32_bit_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
`ifdef DM12_BROADCAST_EN
  input  logic             in_bcast,
`endif
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [PTR_W:0]   count_q  [2];
  logic [PTR_W:0]   count_d  [2];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  assign out_ready = {out1_ready, out0_ready};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      full[k]  = (count_q[k] == CNT_FULL);
      empty[k] = (count_q[k] == '0);
    end
  end

  // in_ready depends only on in_sel (and in_bcast) and registered counts, so
  // consumer ready never ripples combinationally back to the producer.
  always_comb begin
    in_ready = 1'b0;
    push     = 2'b00;
`ifdef DM12_BROADCAST_EN
    if (in_bcast) begin
      in_ready = ~full[0] & ~full[1];
      push     = {2{in_valid & in_ready}};
    end else begin
      in_ready = in_sel ? ~full[1] : ~full[0];
      push[0]  = in_valid & in_ready & ~in_sel;
      push[1]  = in_valid & in_ready &  in_sel;
    end
`else
    in_ready = in_sel ? ~full[1] : ~full[0];
    push[0]  = in_valid & in_ready & ~in_sel;
    push[1]  = in_valid & in_ready &  in_sel;
`endif
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      pop[k]      = ~empty[k] & out_ready[k];
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      count_d[k]  = count_q[k];
      // DEPTH is a power of two, so the pointer wraps naturally.
      if (push[k]) wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
      if (pop[k])  rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
      if (push[k] && !pop[k])      count_d[k] = count_q[k] + (PTR_W+1)'(1);
      else if (pop[k] && !push[k]) count_d[k] = count_q[k] - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[k][i] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) mem_q[k][wr_ptr_q[k]] <= in_data;
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        count_q[k]  <= count_d[k];
      end
    end
  end

  assign out0_valid = ~empty[0];
  assign out1_valid = ~empty[1];
  assign out0_data  = mem_q[0][rd_ptr_q[0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1]];

endmodule

// File: tb/tb_dm12_32_bit_buf.sv
module tb_dm12_32_bit_buf;
  localparam int W = 32;
  localparam int D = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;
`ifdef DM12_BROADCAST_EN
  logic         in_bcast;
`endif

  dm12_32_bit_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
`ifdef DM12_BROADCAST_EN
    .in_bcast   (in_bcast),
`endif
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  always #5 clock = ~clock;

  // Reference model: one queue per channel holding the words the DUT should
  // currently hold, oldest first.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  logic         pend_v   = 1'b0;
  logic         pend_sel = 1'b0;
  logic         pend_b   = 1'b0;
  logic         pend_rst = 1'b0;
  logic [W-1:0] pend_d   = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: fold last cycle's handshake into the model at the edge,
  // drive new inputs, then check in_ready against the model occupancy.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                      input logic r0, input logic r1, input logic rst,
                      input logic b, output logic acc);
    logic exp_rdy;
    @(posedge clock);
    if (pend_rst) begin
      q0.delete();
      q1.delete();
    end else if (pend_v) begin
      if (pend_b || !pend_sel) q0.push_back(pend_d);
      if (pend_b ||  pend_sel) q1.push_back(pend_d);
    end
    pend_v   = 1'b0;
    pend_rst = 1'b0;
    #1;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    reset      = rst;
`ifdef DM12_BROADCAST_EN
    in_bcast   = b;
`endif
    #1;
    if (b) exp_rdy = (q0.size() < D) && (q1.size() < D);
    else   exp_rdy = s ? (q1.size() < D) : (q0.size() < D);
    if (mon_en) chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    acc      = v && in_ready && !rst;
    pend_v   = acc;
    pend_sel = s;
    pend_d   = d;
    pend_b   = b;
    pend_rst = rst;
  endtask

  // Monitor: mid-cycle, compare each channel's presented head with the model.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() != 0});
      if (out0_valid && q0.size() != 0) begin
        chk("out0_data", out0_data, q0[0]);
        if (out0_ready) void'(q0.pop_front());
      end
      chk("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
      if (out1_valid && q1.size() != 0) begin
        chk("out1_data", out1_data, q1[0]);
        if (out1_ready) void'(q1.pop_front());
      end
    end
  end

  initial begin
    logic         acc;
    logic         hold;
    logic         hv;
    logic         hs;
    logic         hb;
    logic [W-1:0] hd;
    int           guard;

    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
`ifdef DM12_BROADCAST_EN
    in_bcast = 1'b0;
`endif

    // Reset then idle.
    step(0, 0, '0, 0, 0, 1, 0, acc);
    step(0, 0, '0, 0, 0, 1, 0, acc);
    mon_en = 1'b1;
    step(0, 0, '0, 0, 0, 0, 0, acc);
    chk("rst out0_valid", {31'b0, out0_valid}, '0);
    chk("rst out1_valid", {31'b0, out1_valid}, '0);
    chk("rst out0_data", out0_data, '0);
    chk("rst out1_data", out1_data, '0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);

    // Steering.
    step(1, 0, 32'hDEADBEEF, 1, 1, 0, 0, acc);
    step(1, 1, 32'h12345678, 1, 1, 0, 0, acc);
    chk("steer ch0 head", out0_data, 32'hDEADBEEF);
    step(0, 0, '0, 1, 1, 0, 0, acc);
    chk("steer ch1 head", out1_data, 32'h12345678);
    step(0, 0, '0, 1, 1, 0, 0, acc);

    // Backpressure / full on channel 0, channel 1 stays open.
    step(1, 0, 32'h1, 0, 1, 0, 0, acc);
    step(1, 0, 32'h2, 0, 1, 0, 0, acc);
    step(1, 0, 32'h3, 0, 1, 0, 0, acc);
    chk("full blocks ch0", {31'b0, acc}, '0);
    step(1, 1, 32'hA, 0, 1, 0, 0, acc);
    chk("ch1 open while ch0 full", {31'b0, acc}, 32'd1);
    acc = 1'b0;
    for (guard = 0; guard < 10 && !acc; guard++) step(1, 0, 32'h3, 1, 1, 0, 0, acc);
    chk("held word accepted", {31'b0, acc}, 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 1, 0, 0, acc);

    // Throughput with pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(1, i[0], W'(i), 1, 1, 0, 0, acc);
      chk("stream no stall", {31'b0, acc}, 32'd1);
    end
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1, 0, 0, acc);

    // Reset mid-operation with a handshake attempt on ch0.
    step(1, 0, 32'h11, 0, 0, 0, 0, acc);
    step(1, 0, 32'h22, 0, 0, 0, 0, acc);
    step(1, 1, 32'h55, 0, 0, 1, 0, acc);
    step(0, 0, '0, 0, 0, 0, 0, acc);
    chk("midrst out0_valid", {31'b0, out0_valid}, '0);
    chk("midrst out1_valid", {31'b0, out1_valid}, '0);
    chk("midrst out0_data", out0_data, '0);

`ifdef DM12_BROADCAST_EN
    // Broadcast blocked by a full channel 1, then released.
    step(1, 1, 32'hB1, 1, 0, 0, 0, acc);
    step(1, 1, 32'hB2, 1, 0, 0, 0, acc);
    step(1, 0, 32'hCAFEF00D, 1, 0, 0, 1, acc);
    chk("bcast blocked", {31'b0, acc}, '0);
    acc = 1'b0;
    for (guard = 0; guard < 10 && !acc; guard++) step(1, 0, 32'hCAFEF00D, 1, 1, 0, 1, acc);
    chk("bcast accepted", {31'b0, acc}, 32'd1);
    step(0, 0, '0, 0, 1, 0, 0, acc);
    chk("bcast ch0 head", out0_data, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 1, 0, 0, acc);
`endif

    // Randomized traffic; an unaccepted word is held stable.
    hold = 1'b0; hv = 1'b0; hs = 1'b0; hb = 1'b0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      logic rst;
      if (!hold) begin
        hv = ($urandom_range(0, 3) != 0);
        hs = 1'($urandom_range(0, 1));
        hd = $urandom;
`ifdef DM12_BROADCAST_EN
        hb = ($urandom_range(0, 5) == 0);
`endif
      end
      rst = ($urandom_range(0, 60) == 0);
      step(hv, hs, hd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rst, hb, acc);
      hold = hv && !acc && !rst;
    end

    // Drain: everything the model holds must come out within a bound.
    for (guard = 0; guard < 20; guard++) begin
      step(0, 0, '0, 1, 1, 0, 0, acc);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    chk("drain ch0 empty", 32'(q0.size()), '0);
    chk("drain ch1 empty", 32'(q1.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
